arb_mux_4_1: RTL and testbench

ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

---
 rtl/arb_mux_pkg.sv | 16 +
 rtl/arb_mux_4_1_rr_pick.sv | 37 +++
 rtl/arb_mux_4_1.sv | 72 +++++++
 tb/tb_arb_mux_4_1.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the 4:1 round-robin arbitrating multiplexer.
// The top and the winner picker both import this package.
package arb_mux_pkg;

    localparam int N_PORTS = 4;
    localparam int W       = 4;

    typedef logic [W-1:0] data_t;
    typedef logic [1:0]   idx_t;

    // Port index after idx; the 2-bit width makes 3 wrap to 0.
    function automatic idx_t next_idx(input idx_t idx);
        next_idx = idx + 2'd1;
    endfunction

endpackage

// File: rtl/arb_mux_4_1_rr_pick.sv
// Combinational round-robin winner picker for four requesters.
// It scans from ptr upward and wraps around.
module rr_pick_4
    import arb_mux_pkg::*;
(
    input  logic [3:0] in_valid,
    input  idx_t       ptr,
    output logic [3:0] grant_onehot,
    output idx_t       grant_idx,
    output logic       any_valid
);

    logic [7:0] dbl;
    logic [3:0] rot;
    idx_t       off;
    logic       found;

    // Rotate so that bit 0 of rot is the port ptr points at.
    // The first set bit of rot is then the winner's offset from ptr.
    always_comb begin
        dbl   = {in_valid, in_valid};
        rot   = dbl[ptr +: 4];
        off   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && rot[i]) begin
                off   = idx_t'(i);
                found = 1'b1;
            end
        end
    end

    assign any_valid    = |in_valid;
    assign grant_idx    = ptr + off;
    assign grant_onehot = any_valid ? (4'b0001 << grant_idx) : 4'b0000;

endmodule

// File: rtl/arb_mux_4_1.sv
// Four-input round-robin arbitrating multiplexer with a single registered output slot.
// The output slot is handshaked with valid/ready.
module arb_mux_4_1 #(
    parameter int N_PORTS = 4,
    parameter int W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       d0,
    input  logic [W-1:0]       d1,
    input  logic [W-1:0]       d2,
    input  logic [W-1:0]       d3,
    input  logic [N_PORTS-1:0] in_valid,
    output logic [N_PORTS-1:0] in_ready,
    output logic [W-1:0]       y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [1:0]         sel
);
    import arb_mux_pkg::*;

    idx_t       ptr;
    logic [3:0] grant_onehot;
    idx_t       grant_idx;
    logic       any_valid;
    logic       slot_free;
    logic       take;
    logic [W-1:0] win_data_p0;

    // Stage 0: arbitration and data select, purely combinational
    rr_pick_4 u_pick (
        .in_valid     (in_valid),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_valid    (any_valid)
    );

    assign slot_free = !y_valid || y_ready;
    // rst_n gates the grant so that no port sees ready while reset is held.
    assign take      = rst_n && slot_free && any_valid;
    assign in_ready  = take ? grant_onehot : '0;

    always_comb begin
        case (grant_idx)
            2'd0:    win_data_p0 = d0;
            2'd1:    win_data_p0 = d1;
            2'd2:    win_data_p0 = d2;
            default: win_data_p0 = d3;
        endcase
    end

    // Stage 1: output slot register and pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            sel     <= 2'd0;
            y_valid <= 1'b0;
            ptr     <= 2'd0;
        end else if (slot_free) begin
            if (any_valid) begin
                y       <= win_data_p0;
                sel     <= grant_idx;
                y_valid <= 1'b1;
                ptr     <= next_idx(grant_idx);
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Directed self-checking bench for arb_mux_4_1.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_arb_mux_4_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] sel;

    int passed = 0;
    int total  = 0;

    arb_mux_4_1 #(.N_PORTS(4), .W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        y_ready  = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        #2;
        total++;
        if ({y, sel, y_valid, in_ready} !== {4'h0, 2'd0, 1'b0, 4'b0000})
            $display("FAIL reset_async: got y=%h sel=%0d yv=%b rdy=%b want 0 0 0 0000", y, sel, y_valid, in_ready);
        else passed++;
        tick;
        total++;
        if ({y, sel, y_valid, in_ready} !== {4'h0, 2'd0, 1'b0, 4'b0000})
            $display("FAIL reset_held: got y=%h sel=%0d yv=%b rdy=%b want 0 0 0 0000", y, sel, y_valid, in_ready);
        else passed++;
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
        logic [3:0] exp_y;
        in_valid = 4'b1111;
        y_ready  = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001)
            $display("FAIL rr_first_ready: got %b want 0001", in_ready);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            tick;
            exp_sel = 2'(k % 4);
            exp_y   = 4'((k % 4) + 1);
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            total++;
            if ({y, sel, y_valid} !== {exp_y, exp_sel, 1'b1})
                $display("FAIL rr_grant%0d: got y=%h sel=%0d yv=%b want y=%h sel=%0d yv=1", k, y, sel, y_valid, exp_y, exp_sel);
            else passed++;
            total++;
            if (in_ready !== exp_rdy)
                $display("FAIL rr_ready%0d: got %b want %b", k, in_ready, exp_rdy);
            else passed++;
        end
        in_valid = 4'b0000;
        tick;
        total++;
        if (y_valid !== 1'b0)
            $display("FAIL rr_idle: got yv=%b want 0", y_valid);
        else passed++;
    endtask

    task automatic test_sparse_wrap;
        // ptr is 0 here; one grant on port 0 moves it to 1
        in_valid = 4'b0001;
        tick;
        in_valid = 4'b1001;
        #1;
        total++;
        if (in_ready !== 4'b1000)
            $display("FAIL wrap_ready: got %b want 1000", in_ready);
        else passed++;
        d0 = 4'hF; d3 = 4'hE;
        #1;
        total++;
        if (in_ready !== 4'b1000)
            $display("FAIL wrap_data_indep: got %b want 1000", in_ready);
        else passed++;
        d0 = 4'd1; d3 = 4'd4;
        tick;
        total++;
        if ({y, sel, y_valid, in_ready} !== {4'd4, 2'd3, 1'b1, 4'b0001})
            $display("FAIL wrap_port3: got y=%h sel=%0d yv=%b rdy=%b want 4 3 1 0001", y, sel, y_valid, in_ready);
        else passed++;
        tick;
        total++;
        if ({y, sel, y_valid} !== {4'd1, 2'd0, 1'b1})
            $display("FAIL wrap_port0: got y=%h sel=%0d yv=%b want 1 0 1", y, sel, y_valid);
        else passed++;
        in_valid = 4'b0000;
        tick;
    endtask

    task automatic test_backpressure;
        // ptr is 1: grant port 1 first to get a held item
        in_valid = 4'b0010;
        tick;
        y_ready  = 1'b0;
        in_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000)
                $display("FAIL bp_ready%0d: got %b want 0000", k, in_ready);
            else passed++;
            tick;
            total++;
            if ({y, sel, y_valid} !== {4'd2, 2'd1, 1'b1})
                $display("FAIL bp_hold%0d: got y=%h sel=%0d yv=%b want 2 1 1", k, y, sel, y_valid);
            else passed++;
        end
        y_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100)
            $display("FAIL bp_release_ready: got %b want 0100", in_ready);
        else passed++;
        tick;
        total++;
        if ({y, sel, y_valid} !== {4'd3, 2'd2, 1'b1})
            $display("FAIL bp_release_grant: got y=%h sel=%0d yv=%b want 3 2 1", y, sel, y_valid);
        else passed++;
        in_valid = 4'b0000;
        tick;
    endtask

    task automatic test_drain;
        // ptr is 3 here; only port 2 requests, so the scan wraps to it
        d2       = 4'hA;
        in_valid = 4'b0100;
        #1;
        total++;
        if (in_ready !== 4'b0100)
            $display("FAIL drain_ready: got %b want 0100", in_ready);
        else passed++;
        tick;
        in_valid = 4'b0000;
        total++;
        if ({y, sel, y_valid} !== {4'hA, 2'd2, 1'b1})
            $display("FAIL drain_load: got y=%h sel=%0d yv=%b want a 2 1", y, sel, y_valid);
        else passed++;
        tick;
        total++;
        if ({y, sel, y_valid} !== {4'hA, 2'd2, 1'b0})
            $display("FAIL drain_empty: got y=%h sel=%0d yv=%b want a 2 0", y, sel, y_valid);
        else passed++;
        tick;
        total++;
        if (y_valid !== 1'b0)
            $display("FAIL drain_stay_empty: got yv=%b want 0", y_valid);
        else passed++;
        d2 = 4'd3;
    endtask

    task automatic test_mid_reset;
        // ptr is 3 after the drain grant on port 2
        in_valid = 4'b1111;
        tick;
        y_ready = 1'b0;
        total++;
        if ({y, sel, y_valid} !== {4'd4, 2'd3, 1'b1})
            $display("FAIL midrst_pre: got y=%h sel=%0d yv=%b want 4 3 1", y, sel, y_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({y, sel, y_valid, in_ready} !== {4'h0, 2'd0, 1'b0, 4'b0000})
            $display("FAIL midrst_clear: got y=%h sel=%0d yv=%b rdy=%b want 0 0 0 0000", y, sel, y_valid, in_ready);
        else passed++;
        #4;
        rst_n   = 1'b1;
        y_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001)
            $display("FAIL midrst_ready: got %b want 0001", in_ready);
        else passed++;
        tick;
        total++;
        if ({y, sel, y_valid} !== {4'd1, 2'd0, 1'b1})
            $display("FAIL midrst_grant: got y=%h sel=%0d yv=%b want 1 0 1", y, sel, y_valid);
        else passed++;
        in_valid = 4'b0000;
        tick;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_sparse_wrap;
        test_backpressure;
        test_drain;
        test_mid_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
